nic_access_ctrl: RTL and testbench
==================================

NIC_ACCESS_CTRL -- requirements
Module: nic_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive not-ready ISSUE cycles before an access aborts.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port nic_en, input, 1 bit: the decoded instruction is a NIC access.
REQ-005 The block SHALL have port nic_wr, input, 1 bit: 1 = store to NIC, 0 = load from NIC.
REQ-006 The block SHALL have port nic_addr, input, 2 bits: NIC register select (00 input buffer, 01 input status, 10 output buffer, 11 output status).
REQ-007 The block SHALL have port wr_data, input, 64 bits: store data from the register file.
REQ-008 The block SHALL have port stall, output, 1 bit: holds the pipeline front end.
REQ-009 The block SHALL have port rd_data, output, 64 bits: load result, registered.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse; rd_data valid.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal access or a timeout.
REQ-012 The block SHALL have port nic_req_en, output, 1 bit: NIC port request.
REQ-013 The block SHALL have port nic_req_wr, output, 1 bit: NIC port write strobe qualifier.
REQ-014 The block SHALL have port nic_req_addr, output, 2 bits: latched register select.
REQ-015 The block SHALL have port nic_req_dout, output, 64 bits: latched store data.
REQ-016 The block SHALL have port nic_ready, input, 1 bit: NIC accepts the request this cycle.
REQ-017 The block SHALL have port nic_din, input, 64 bits: NIC read data, valid when nic_ready=1.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP; the state register is updated on the rising edge of clk.
REQ-019 In IDLE with nic_en=1, the block SHALL latch nic_wr, nic_addr and wr_data into internal registers and clear the wait counter.
REQ-020 From IDLE with nic_en=1, the next state SHALL be ISSUE, except for a write with nic_addr≠10, which SHALL go directly to RESP with an err pending and no NIC request.
REQ-021 In IDLE with nic_en=0, the block SHALL remain in IDLE and hold all request outputs at 0.
REQ-022 stall SHALL be combinational: 1 when (state=IDLE and nic_en=1) or state=ISSUE; 0 in RESP, and 0 in IDLE when nic_en=0.
REQ-023 In ISSUE, the block SHALL drive nic_req_en=1 and drive nic_req_wr, nic_req_addr and nic_req_dout from the latched values, which SHALL stay stable for the whole ISSUE period.
REQ-024 In ISSUE with nic_ready=1, the block SHALL go to RESP; on a load it SHALL capture nic_din into rd_data on the same edge.
REQ-025 In ISSUE with nic_ready=0, the block SHALL increment the wait counter; when the counter reaches TIMEOUT-1 it SHALL go to RESP with an err pending and SHALL set rd_data to 0.
REQ-026 In RESP, nic_req_en SHALL be 0.
REQ-027 In RESP, rd_valid SHALL be 1 only for a successful load, and err SHALL be 1 only if an err is pending.
REQ-028 From RESP, the next state SHALL be IDLE unconditionally; nic_en in RESP SHALL be ignored, because the stalled instruction retires in that cycle.
REQ-029 A successful access SHALL take exactly 3 cycles in total (IDLE-detect, ISSUE, RESP) when nic_ready=1 on the first ISSUE cycle; each not-ready cycle SHALL add 1 cycle.
REQ-030 Back-to-back accesses SHALL be supported: nic_en=1 on the cycle after RESP SHALL start a new access immediately.
REQ-031 rd_data SHALL hold its last value outside capture and timeout events.
REQ-032 Reads of any nic_addr SHALL be legal.
REQ-033 Writes SHALL be legal only to nic_addr 10.
REQ-034 The wait counter SHALL be log2(TIMEOUT)+1 bits wide and SHALL saturate; it SHALL never wrap.

Reset
REQ-035 With reset=1 at a rising edge, the block SHALL set the state to IDLE, clear the wait counter, latched fields and rd_data to 0, and clear any pending err.
REQ-036 While reset is high, stall, rd_valid, err, nic_req_en and nic_req_wr SHALL read 0, with reset overriding nic_en.
REQ-037 A reset asserted mid-ISSUE SHALL abort the access with no rd_valid and no err; nic_req_en SHALL be 0 from the reset edge onward.

Verification
REQ-038 Load at addr 01 with nic_ready=1 on the first ISSUE cycle and nic_din=64'h0000_0000_0000_0001 -> stall=1 for 2 cycles, then rd_valid=1 and rd_data=1 in RESP; total 3 cycles.
REQ-039 Store at addr 10 with wr_data=64'hDEAD_BEEF_0000_1234, nic_ready low for 3 ISSUE cycles then high -> nic_req_dout stable for 4 ISSUE cycles, nic_req_wr=1, no rd_valid, no err.
REQ-040 Store at addr 00 -> no nic_req_en at any time; err=1 in the second cycle; stall=1 for 1 cycle only.
REQ-041 Load at addr 11 with nic_ready held at 0 -> err=1 after 16 ISSUE cycles, rd_data=0, return to IDLE.
REQ-042 Reset asserted on the 2nd ISSUE cycle of a load -> state IDLE, nic_req_en=0, no rd_valid and no err after the reset edge.
REQ-043 Two loads back-to-back, each with nic_ready=1 -> two rd_valid pulses exactly 3 cycles apart.

Source files
------------

// File: rtl/nic_access_ctrl.sv
// Purpose: sequences one NIC register load/store per stalled instruction (IDLE -> ISSUE -> RESP).
// Latency: 3 cycles from nic_en to retire when nic_ready is high on the first ISSUE cycle; +1 per not-ready cycle.
// Backpressure: nic_ready low holds ISSUE (pipeline stalled) until accepted or the wait counter times out.
module nic_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nic_en,
    input  logic        nic_wr,
    input  logic [1:0]  nic_addr,
    input  logic [63:0] wr_data,
    output logic        stall,
    output logic [63:0] rd_data,
    output logic        rd_valid,
    output logic        err,
    output logic        nic_req_en,
    output logic        nic_req_wr,
    output logic [1:0]  nic_req_addr,
    output logic [63:0] nic_req_dout,
    input  logic        nic_ready,
    input  logic [63:0] nic_din
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [1:0]    ADDR_OBUF = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [1:0]    addr_q, addr_d;
    logic [63:0]   dout_q, dout_d;
    logic [63:0]   rd_data_q, rd_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;     // err to be reported in RESP
    logic          ok_q, ok_d;       // load completed, rd_valid in RESP

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields, wait counter, load result and pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q      <= 1'b0;
            addr_q    <= 2'b00;
            dout_q    <= 64'd0;
            rd_data_q <= 64'd0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
        end
    end

    // Next-state and datapath update for the access sequence.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ok_d      = ok_q;
        unique case (state_q)
            IDLE: begin
                if (nic_en) begin
                    wr_d   = nic_wr;
                    addr_d = nic_addr;
                    dout_d = wr_data;
                    cnt_d  = '0;
                    ok_d   = 1'b0;
                    // Stores are only meaningful to the output buffer; others
                    // are rejected without touching the NIC.
                    if (nic_wr && (nic_addr != ADDR_OBUF)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (nic_ready) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        rd_data_d = nic_din;
                        ok_d      = 1'b1;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    rd_data_d = 64'd0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                // The stalled instruction retires here, so nic_en is ignored.
                state_d = IDLE;
                err_d   = 1'b0;
                ok_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall        = !reset && (((state_q == IDLE) && nic_en) || (state_q == ISSUE));
    assign rd_valid     = !reset && (state_q == RESP) && ok_q;
    assign err          = !reset && (state_q == RESP) && err_q;
    assign nic_req_en   = !reset && (state_q == ISSUE);
    assign nic_req_wr   = nic_req_en && wr_q;
    assign nic_req_addr = nic_req_en ? addr_q : 2'b00;
    assign nic_req_dout = nic_req_en ? dout_q : 64'd0;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_nic_access_ctrl.sv
// Purpose: directed self-checking bench for nic_access_ctrl.
// Latency: inputs change 1 time unit after each rising edge, outputs checked after settling.
// Backpressure: nic_ready driven per-cycle from each scenario task.
module tb_nic_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        nic_en;
    logic        nic_wr;
    logic [1:0]  nic_addr;
    logic [63:0] wr_data;
    logic        stall;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        nic_req_en;
    logic        nic_req_wr;
    logic [1:0]  nic_req_addr;
    logic [63:0] nic_req_dout;
    logic        nic_ready;
    logic [63:0] nic_din;

    int total = 0;
    int bad   = 0;

    nic_access_ctrl #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .nic_en       (nic_en),
        .nic_wr       (nic_wr),
        .nic_addr     (nic_addr),
        .wr_data      (wr_data),
        .stall        (stall),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .err          (err),
        .nic_req_en   (nic_req_en),
        .nic_req_wr   (nic_req_wr),
        .nic_req_addr (nic_req_addr),
        .nic_req_dout (nic_req_dout),
        .nic_ready    (nic_ready),
        .nic_din      (nic_din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags order in packed checks: {stall, rd_valid, err, nic_req_en}
    task automatic test_reset();
        reset = 1'b1; nic_en = 1'b1; nic_wr = 1'b0; nic_addr = 2'b01;
        wr_data = 64'd0; nic_ready = 1'b0; nic_din = 64'd0;
        #1;
        total++;
        if ({stall, rd_valid, err, nic_req_en, nic_req_wr} !== 5'b00000) begin
            bad++; $display("FAIL reset_outputs: got %b expected 00000", {stall, rd_valid, err, nic_req_en, nic_req_wr});
        end
        tick(); tick();
        total++;
        if (rd_data !== 64'd0) begin
            bad++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        nic_en = 1'b0; reset = 1'b0;
        #1;
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0000) begin
            bad++; $display("FAIL idle_outputs: got %b expected 0000", {stall, rd_valid, err, nic_req_en});
        end
    endtask

    task automatic test_load();
        nic_en = 1'b1; nic_wr = 1'b0; nic_addr = 2'b01;
        nic_ready = 1'b1; nic_din = 64'h0000_0000_0000_0001;
        #1;
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b1000) begin
            bad++; $display("FAIL load_detect: got %b expected 1000", {stall, rd_valid, err, nic_req_en});
        end
        tick();
        total++;
        if ({stall, nic_req_en, nic_req_wr, nic_req_addr} !== 5'b11001) begin
            bad++; $display("FAIL load_issue: got %b expected 11001", {stall, nic_req_en, nic_req_wr, nic_req_addr});
        end
        tick();
        // nic_en still high in RESP: must be ignored
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0100 || rd_data !== 64'd1) begin
            bad++; $display("FAIL load_resp: got %b/%h expected 0100/1", {stall, rd_valid, err, nic_req_en}, rd_data);
        end
        nic_en = 1'b0; nic_ready = 1'b0; nic_din = 64'h55;
        tick();
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0000 || rd_data !== 64'd1) begin
            bad++; $display("FAIL load_hold: got %b/%h expected 0000/1", {stall, rd_valid, err, nic_req_en}, rd_data);
        end
    endtask

    task automatic test_store_wait();
        nic_en = 1'b1; nic_wr = 1'b1; nic_addr = 2'b10;
        wr_data = 64'hDEAD_BEEF_0000_1234; nic_ready = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1 || nic_req_en !== 1'b0) begin
            bad++; $display("FAIL store_detect: got stall=%b req_en=%b expected 1/0", stall, nic_req_en);
        end
        tick();
        nic_en = 1'b0; wr_data = 64'h1111_2222_3333_4444; nic_addr = 2'b00; nic_wr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            nic_ready = (c == 3);
            #1;
            total++;
            if ({stall, rd_valid, err, nic_req_en, nic_req_wr} !== 5'b10011 ||
                nic_req_addr !== 2'b10 || nic_req_dout !== 64'hDEAD_BEEF_0000_1234) begin
                bad++; $display("FAIL store_issue%0d: got %b/%b/%h expected 10011/10/deadbeef00001234",
                                c, {stall, rd_valid, err, nic_req_en, nic_req_wr}, nic_req_addr, nic_req_dout);
            end
            tick();
        end
        nic_ready = 1'b0;
        #1;
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0000 || rd_data !== 64'd1) begin
            bad++; $display("FAIL store_resp: got %b/%h expected 0000/1", {stall, rd_valid, err, nic_req_en}, rd_data);
        end
        tick();
    endtask

    task automatic test_bad_store();
        nic_en = 1'b1; nic_wr = 1'b1; nic_addr = 2'b00; wr_data = 64'hABCD;
        nic_ready = 1'b1;
        #1;
        total++;
        if ({stall, err, nic_req_en} !== 3'b100) begin
            bad++; $display("FAIL badst_detect: got %b expected 100", {stall, err, nic_req_en});
        end
        tick();
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0010) begin
            bad++; $display("FAIL badst_resp: got %b expected 0010", {stall, rd_valid, err, nic_req_en});
        end
        nic_en = 1'b0;
        tick();
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0000) begin
            bad++; $display("FAIL badst_idle: got %b expected 0000", {stall, rd_valid, err, nic_req_en});
        end
        nic_ready = 1'b0;
    endtask

    task automatic test_timeout();
        nic_en = 1'b1; nic_wr = 1'b0; nic_addr = 2'b11; nic_ready = 1'b0;
        nic_din = 64'hFFFF_0000_FFFF_0000;
        #1;
        tick();
        nic_en = 1'b0;
        for (int c = 0; c < 16; c++) begin
            total++;
            if ({stall, rd_valid, err, nic_req_en} !== 4'b1001 || nic_req_addr !== 2'b11) begin
                bad++; $display("FAIL timeout_issue%0d: got %b/%b expected 1001/11",
                                c, {stall, rd_valid, err, nic_req_en}, nic_req_addr);
            end
            tick();
        end
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0010 || rd_data !== 64'd0) begin
            bad++; $display("FAIL timeout_resp: got %b/%h expected 0010/0", {stall, rd_valid, err, nic_req_en}, rd_data);
        end
        tick();
        total++;
        if ({stall, rd_valid, err, nic_req_en} !== 4'b0000) begin
            bad++; $display("FAIL timeout_idle: got %b expected 0000", {stall, rd_valid, err, nic_req_en});
        end
    endtask

    task automatic test_reset_mid();
        // Give rd_data a nonzero value first so the reset clear is visible.
        nic_en = 1'b1; nic_wr = 1'b0; nic_addr = 2'b00; nic_ready = 1'b1; nic_din = 64'h77;
        #1; tick(); tick();
        nic_en = 1'b0; nic_ready = 1'b0;
        tick();
        nic_en = 1'b1; nic_addr = 2'b00;
        #1; tick();
        nic_en = 1'b0;
        tick();
        total++;
        if (nic_req_en !== 1'b1 || rd_data !== 64'h77) begin
            bad++; $display("FAIL rstmid_issue2: got req_en=%b rd_data=%h expected 1/77", nic_req_en, rd_data);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({stall, rd_valid, err, nic_req_en, nic_req_wr} !== 5'b00000) begin
            bad++; $display("FAIL rstmid_gated: got %b expected 00000", {stall, rd_valid, err, nic_req_en, nic_req_wr});
        end
        tick();
        reset = 1'b0;
        nic_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({stall, rd_valid, err, nic_req_en} !== 4'b0000 || rd_data !== 64'd0) begin
                bad++; $display("FAIL rstmid_after%0d: got %b/%h expected 0000/0",
                                c, {stall, rd_valid, err, nic_req_en}, rd_data);
            end
            tick();
        end
        nic_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        int pulses;
        first_cyc = -1;
        pulses    = 0;
        nic_en = 1'b1; nic_wr = 1'b0; nic_addr = 2'b00; nic_ready = 1'b1;
        nic_din = 64'hAAAA_0000_0000_0001;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) nic_din = 64'hBBBB_0000_0000_0002;
            if (c == 6) nic_en = 1'b0;
            #1;
            if (rd_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = c;
                    total++;
                    if (rd_data !== 64'hAAAA_0000_0000_0001) begin
                        bad++; $display("FAIL b2b_data1: got %h expected aaaa000000000001", rd_data);
                    end
                end else if (pulses == 2) begin
                    total++;
                    if (c - first_cyc !== 3) begin
                        bad++; $display("FAIL b2b_spacing: got %0d expected 3", c - first_cyc);
                    end
                    total++;
                    if (rd_data !== 64'hBBBB_0000_0000_0002) begin
                        bad++; $display("FAIL b2b_data2: got %h expected bbbb000000000002", rd_data);
                    end
                end
            end
            tick();
        end
        total++;
        if (pulses !== 2 || first_cyc !== 2) begin
            bad++; $display("FAIL b2b_pulses: got count=%0d first=%0d expected 2/2", pulses, first_cyc);
        end
        nic_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_store_wait();
        test_bad_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
